lrf_axis_delay_line: RTL

- Parametrised AXI-Stream delay line for the LRF fusion datapath; replaces the single-register pass-through stub.
- Provides DELAY elastic register stages with correct per-stage backpressure, so tready is honoured and no beat is lost or duplicated.
- Counts beats per frame and reports completed frames.
- Sits between input DMA and fusion core; used to latency-match side paths.

---
 rtl/lrf_axis_delay_line.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lrf_axis_delay_line.sv
// AXI-Stream delay line: DELAY elastic stages with a per-stage ready chain, plus frame counting.
// Optional LRF_FRAME_CHECK_EN regenerates tlast from the beat count and flags misplaced input tlast.
module lrf_axis_delay_line #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int DELAY           = 10,
  parameter int FRAME_BEATS     = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
  parameter int CNT_W           = 16
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  frame_err
);

  localparam int BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(FRAME_BEATS - 1);

  logic [DELAY-1:0]      vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [DELAY];
  logic [DATA_WIDTH-1:0] data_d [DELAY];
  logic [DELAY:0]        rdy;
  logic [BCW-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  in_xfer, out_xfer;

  // rdy[i] expanded as "downstream ready or any stage at/after i empty" to avoid a self-referencing vector
  always_comb begin
    for (int unsigned i = 0; i <= DELAY; i++) begin
      rdy[i] = m_axis_tready;
      for (int unsigned j = i; j < DELAY; j++) begin
        if (!vld_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign s_axis_tready = rdy[0];
  assign in_xfer       = s_axis_tvalid & rdy[0];
  assign out_xfer      = vld_q[DELAY-1] & m_axis_tready;
  assign m_axis_tvalid = vld_q[DELAY-1];
  assign m_axis_tdata  = data_q[DELAY-1];
  assign frame_count   = frame_cnt_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (rdy[0]) begin
      vld_d[0]  = s_axis_tvalid;
      data_d[0] = s_axis_tdata;
    end
    for (int unsigned i = 1; i < DELAY; i++) begin
      if (rdy[i]) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_comb begin
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (out_xfer) begin
      if (out_cnt_q == LAST_BEAT) begin
        out_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end else begin
        out_cnt_d = out_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      vld_q       <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < DELAY; i++) data_q[i] <= '0;
    end else begin
      vld_q       <= vld_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      for (int unsigned i = 0; i < DELAY; i++) data_q[i] <= data_d[i];
    end
  end

`ifdef LRF_FRAME_CHECK_EN
  logic [BCW-1:0] in_cnt_q, in_cnt_d;
  logic           frame_err_q, frame_err_d;

  always_comb begin
    in_cnt_d    = in_cnt_q;
    frame_err_d = frame_err_q;
    if (in_xfer) begin
      in_cnt_d = (in_cnt_q == LAST_BEAT) ? '0 : in_cnt_q + BCW'(1);
      if (s_axis_tlast != (in_cnt_q == LAST_BEAT)) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      in_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err    = frame_err_q;
  assign m_axis_tlast = vld_q[DELAY-1] & (out_cnt_q == LAST_BEAT);
`else
  logic [DELAY-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (rdy[0]) last_d[0] = s_axis_tlast;
    for (int unsigned i = 1; i < DELAY; i++) begin
      if (rdy[i]) last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) last_q <= '0;
    else               last_q <= last_d;
  end

  assign frame_err    = 1'b0;
  assign m_axis_tlast = last_q[DELAY-1];
`endif

endmodule
